// File: rtl/string_hw_pkg.sv
// Shared types and constants for the string hardware sequencer: FSM states,
// register map, CTRL/STATUS field positions and default sizes.
package string_hw_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int W_DEF     = 32;

    localparam logic [2:0] ADDR_PUSH_A = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_PUSH_B = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_RESULT = 3'd3;

    localparam int CTRL_GO_BIT    = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int CTRL_IDX_LSB   = 2;
    localparam int CTRL_LEN_LSB   = 5;

    localparam int ST_CNT_A_LSB = 0;
    localparam int ST_CNT_B_LSB = 5;
    localparam int ST_CNT_R_LSB = 10;
    localparam int ST_STATE_LSB = 15;
    localparam int ST_BUSY_BIT  = 18;
    localparam int ST_DONE_BIT  = 19;
    localparam int ST_OVF_BIT   = 20;
    localparam int ST_UDF_BIT   = 21;
    localparam int ST_MIS_BIT   = 22;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    function automatic logic [31:0] build_status(
        input logic [4:0] cnt_a,
        input logic [4:0] cnt_b,
        input logic [4:0] cnt_r,
        input seq_state_t st,
        input logic       busy,
        input logic       done,
        input logic       ovf,
        input logic       udf,
        input logic       mis
    );
        logic [31:0] s;
        s                     = 32'd0;
        s[ST_CNT_A_LSB +: 5]  = cnt_a;
        s[ST_CNT_B_LSB +: 5]  = cnt_b;
        s[ST_CNT_R_LSB +: 5]  = cnt_r;
        s[ST_STATE_LSB +: 3]  = st;
        s[ST_BUSY_BIT]        = busy;
        s[ST_DONE_BIT]        = done;
        s[ST_OVF_BIT]         = ovf;
        s[ST_UDF_BIT]         = udf;
        s[ST_MIS_BIT]         = mis;
        return s;
    endfunction

    function automatic logic [7:0] build_ctrl(input logic [2:0] len, input logic [2:0] idx);
        return {len, idx, 2'b00};
    endfunction

endpackage

// File: rtl/string_hw_sequencer_if.sv
// Avalon-MM slave bus bundle for the string sequencer register file.
interface string_hw_sequencer_if
    import string_hw_pkg::*;
#(
    parameter int W = W_DEF
) ();
    logic         chipselect;
    logic         read;
    logic         write;
    logic [2:0]   address;
    logic [W-1:0] writedata;
    logic [W-1:0] readdata;

    modport master (
        output chipselect, read, write, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        output readdata
    );
endinterface

// File: rtl/string_fifo.sv
// Synchronous FIFO with push/pop, occupancy count and a one-cycle flush.
// Overflowing pushes and underflowing pops are silently ignored here.
module string_fifo
    import string_hw_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = W_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == CW'(0));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are only observable through a non-empty head.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_reset) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/string_hw_sequencer.sv
// Avalon-MM controlled sequencer: pairs words from FIFO A and B, hands each
// pair to an external string datapath and queues the results for readback.
module string_hw_sequencer
    import string_hw_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    string_hw_sequencer_if.slave bus,
    output logic                 o_dp_go,
    output logic [W-1:0]         o_dp_a,
    output logic [W-1:0]         o_dp_b,
    output logic [2:0]           o_dp_length,
    output logic [2:0]           o_dp_index,
    input  logic                 i_dp_done,
    input  logic [W-1:0]         i_dp_result
);
    localparam int CW = $clog2(DEPTH + 1);

    seq_state_t    r_state;
    seq_state_t    w_state_next;
    logic [W-1:0]  r_readdata;
    logic          r_dp_go;
    logic [W-1:0]  r_dp_a;
    logic [W-1:0]  r_dp_b;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_pairs;
    logic [2:0]    r_index;
    logic [2:0]    r_length;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_mismatch;

    logic          w_wr, w_rd, w_wr_a, w_wr_b, w_wr_ctrl, w_go, w_clear, w_rd_res;
    logic          w_busy, w_done;
    logic          w_pop_ab, w_load_ops, w_load_res, w_push_r, w_dec_pairs, w_load_pairs, w_set_mis;
    logic          w_full_a, w_full_b, w_full_r, w_empty_a, w_empty_b, w_empty_r;
    logic [CW-1:0] w_count_a, w_count_b, w_count_r;
    logic [W-1:0]  w_head_a, w_head_b, w_head_r;
    logic          w_unused_wdata;

    assign w_wr      = bus.chipselect && bus.write;
    assign w_rd      = bus.chipselect && bus.read;
    assign w_wr_a    = w_wr && (bus.address == ADDR_PUSH_A);
    assign w_wr_b    = w_wr && (bus.address == ADDR_PUSH_B);
    assign w_wr_ctrl = w_wr && (bus.address == ADDR_CTRL);
    assign w_clear   = w_wr_ctrl && bus.writedata[CTRL_CLEAR_BIT];
    assign w_go      = w_wr_ctrl && bus.writedata[CTRL_GO_BIT] && !w_clear;
    assign w_rd_res  = w_rd && (bus.address == ADDR_RESULT);
    assign w_busy    = (r_state == ST_FETCH) || (r_state == ST_ISSUE) ||
                       (r_state == ST_WAIT)  || (r_state == ST_STORE);
    assign w_done    = (r_state == ST_DONE);
    assign w_unused_wdata = ^bus.writedata;

    string_fifo #(.DEPTH(DEPTH), .W(W), .CW(CW)) u_fifo_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(w_clear),
        .i_push(w_wr_a && !w_busy), .i_data(bus.writedata), .i_pop(w_pop_ab),
        .o_head(w_head_a), .o_full(w_full_a), .o_empty(w_empty_a), .o_count(w_count_a)
    );

    string_fifo #(.DEPTH(DEPTH), .W(W), .CW(CW)) u_fifo_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(w_clear),
        .i_push(w_wr_b && !w_busy), .i_data(bus.writedata), .i_pop(w_pop_ab),
        .o_head(w_head_b), .o_full(w_full_b), .o_empty(w_empty_b), .o_count(w_count_b)
    );

    string_fifo #(.DEPTH(DEPTH), .W(W), .CW(CW)) u_fifo_r (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(w_clear),
        .i_push(w_push_r), .i_data(r_result), .i_pop(w_rd_res),
        .o_head(w_head_r), .o_full(w_full_r), .o_empty(w_empty_r), .o_count(w_count_r)
    );

    // Next-state and per-state strobes; CLEAR overrides whatever the state wanted.
    always_comb begin
        w_state_next = r_state;
        w_pop_ab     = 1'b0;
        w_load_ops   = 1'b0;
        w_load_res   = 1'b0;
        w_push_r     = 1'b0;
        w_dec_pairs  = 1'b0;
        w_load_pairs = 1'b0;
        w_set_mis    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_go) begin
                    if (w_count_a != w_count_b) begin
                        w_set_mis = 1'b1;
                    end else if (w_count_a == CW'(0)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_FETCH;
                        w_load_pairs = 1'b1;
                    end
                end else if ((r_state == ST_DONE) && (w_wr_a || w_wr_b)) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_FETCH: begin
                w_pop_ab     = 1'b1;
                w_load_ops   = 1'b1;
                w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_dp_done) begin
                    w_load_res   = 1'b1;
                    w_state_next = ST_STORE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_STORE: begin
                if (!w_full_r) begin
                    w_push_r     = 1'b1;
                    w_dec_pairs  = 1'b1;
                    w_state_next = (r_pairs == CW'(1)) ? ST_DONE : ST_FETCH;
                end else begin
                    w_state_next = ST_STORE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_clear) begin
            w_state_next = ST_IDLE;
            w_pop_ab     = 1'b0;
            w_load_ops   = 1'b0;
            w_load_res   = 1'b0;
            w_push_r     = 1'b0;
            w_dec_pairs  = 1'b0;
            w_load_pairs = 1'b0;
            w_set_mis    = 1'b0;
        end else begin
            w_state_next = w_state_next;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath-facing registers; dp_go is high exactly while in ISSUE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dp_go  <= 1'b0;
            r_dp_a   <= '0;
            r_dp_b   <= '0;
            r_result <= '0;
            r_pairs  <= CW'(0);
            r_index  <= 3'd0;
            r_length <= 3'd0;
        end else begin
            r_dp_go <= (w_state_next == ST_ISSUE);
            if (w_load_ops) begin
                r_dp_a <= w_head_a;
                r_dp_b <= w_head_b;
            end
            if (w_load_res) begin
                r_result <= i_dp_result;
            end
            if (w_clear) begin
                r_pairs <= CW'(0);
            end else if (w_load_pairs) begin
                r_pairs <= w_count_a;
            end else if (w_dec_pairs) begin
                r_pairs <= r_pairs - CW'(1);
            end
            if (w_wr_ctrl) begin
                r_index  <= bus.writedata[CTRL_IDX_LSB +: 3];
                r_length <= bus.writedata[CTRL_LEN_LSB +: 3];
            end
        end
    end

    // Sticky error flags, cleared only by CLEAR or reset.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            if ((w_wr_a && (w_busy || w_full_a)) || (w_wr_b && (w_busy || w_full_b)) ||
                (w_go && w_busy)) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_res && w_empty_r) begin
                r_underflow <= 1'b1;
            end
            if (w_set_mis) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    // Registered read mux; a result read also pops the RESULT FIFO.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            case (bus.address)
                ADDR_STATUS: r_readdata <= W'(build_status(5'(w_count_a), 5'(w_count_b),
                                                           5'(w_count_r), r_state, w_busy, w_done,
                                                           r_overflow, r_underflow, r_mismatch));
                ADDR_CTRL:   r_readdata <= W'(build_ctrl(r_length, r_index));
                ADDR_RESULT: r_readdata <= w_empty_r ? '0 : w_head_r;
                default:     r_readdata <= '0;
            endcase
        end else begin
            r_readdata <= r_readdata;
        end
    end

    assign bus.readdata = r_readdata;
    assign o_dp_go      = r_dp_go;
    assign o_dp_a       = r_dp_a;
    assign o_dp_b       = r_dp_b;
    assign o_dp_length  = r_length;
    assign o_dp_index   = r_index;

endmodule

// File: tb/tb_string_hw_sequencer.sv
// Directed self-checking bench for string_hw_sequencer with a simple
// datapath responder that answers each dp_go after a programmable latency.
module tb_string_hw_sequencer;
    import string_hw_pkg::*;

    localparam int DEPTH = 16;
    localparam int W     = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         dp_go;
    logic [W-1:0] dp_a, dp_b, dp_result;
    logic [2:0]   dp_length, dp_index;
    logic         dp_done;

    int           checks = 0;
    int           errors = 0;
    int           go_cnt = 0;
    logic [31:0]  go_a_log [$];
    int           model_lat = 2;
    logic [31:0]  model_res = 32'h1;

    always #5 clk = ~clk;

    string_hw_sequencer_if #(.W(W)) bus ();

    string_hw_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .i_clk(clk), .i_reset(reset), .bus(bus),
        .o_dp_go(dp_go), .o_dp_a(dp_a), .o_dp_b(dp_b),
        .o_dp_length(dp_length), .o_dp_index(dp_index),
        .i_dp_done(dp_done), .i_dp_result(dp_result)
    );

    // Record every start pulse and the A operand it carried.
    always @(negedge clk) begin
        if (dp_go) begin
            go_cnt <= go_cnt + 1;
            go_a_log.push_back(dp_a);
        end
    end

    // Datapath model: one-cycle done pulse model_lat negedges after dp_go.
    initial begin
        dp_done   = 1'b0;
        dp_result = 32'h0;
        forever begin
            @(negedge clk);
            if (dp_go) begin
                repeat (model_lat) @(negedge clk);
                dp_done   = 1'b1;
                dp_result = model_res;
                @(negedge clk);
                dp_done   = 1'b0;
                dp_result = 32'h0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic av_write(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        bus.address = a; bus.writedata = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic av_read(input logic [2:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0;
        bus.address = a;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic poll_status(input logic [31:0] mask, input logic [31:0] val,
                               input int budget, output logic found, output logic [31:0] st);
        found = 1'b0;
        st    = 32'h0;
        for (int i = 0; i < budget && !found; i++) begin
            av_read(ADDR_STATUS, st);
            if ((st & mask) == val) found = 1'b1;
        end
    endtask

    task automatic do_clear();
        av_write(ADDR_CTRL, 32'h2);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = 3'd0; bus.writedata = 32'h0;
        reset = 1'b1;
        idle(3);
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h expected 0", bus.readdata); end
        checks++; if (dp_go !== 1'b0) begin errors++; $display("FAIL rst_dp_go: got %b expected 0", dp_go); end
        checks++; if (dp_a !== 32'h0 || dp_b !== 32'h0) begin errors++; $display("FAIL rst_operands: got %h/%h expected 0/0", dp_a, dp_b); end
        checks++; if (dp_index !== 3'd0 || dp_length !== 3'd0) begin errors++; $display("FAIL rst_ctrl: got %0d/%0d expected 0/0", dp_index, dp_length); end
        av_write(ADDR_PUSH_A, 32'h1234);
        reset = 1'b0;
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_priority_status: got %h expected 00000000", d); end
        av_read(ADDR_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl_read: got %h expected 00000000", d); end
    endtask

    task automatic test_ctrl();
        logic [31:0] d;
        av_write(ADDR_CTRL, 32'h0000_00AC);
        checks++; if (dp_length !== 3'd5 || dp_index !== 3'd3) begin errors++; $display("FAIL ctrl_ports: got len %0d idx %0d expected 5 3", dp_length, dp_index); end
        av_read(ADDR_CTRL, d);
        checks++; if (d !== 32'h0000_00AC) begin errors++; $display("FAIL ctrl_read: got %h expected 000000ac", d); end
        av_write(3'd5, 32'hFFFF_FFFF);
        av_read(3'd5, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_write_status: got %h expected 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic        found;
        int          g0, n0;
        do_clear();
        model_lat = 2; model_res = 32'h1;
        av_write(ADDR_PUSH_A, 32'h4142_4344); av_write(ADDR_PUSH_A, 32'h4546_4748);
        av_write(ADDR_PUSH_B, 32'h4142_4344); av_write(ADDR_PUSH_B, 32'h4546_4748);
        g0 = go_cnt; n0 = go_a_log.size();
        av_write(ADDR_CTRL, 32'h1);
        poll_status(32'h0008_0000, 32'h0008_0000, 60, found, d);
        checks++; if (!found) begin errors++; $display("FAIL basic_done_timeout: got status %h expected done bit", d); end
        checks++; if (d !== 32'h000A_8800) begin errors++; $display("FAIL basic_status: got %h expected 000a8800", d); end
        checks++; if (go_cnt - g0 !== 2) begin errors++; $display("FAIL basic_go_pulses: got %0d expected 2", go_cnt - g0); end
        checks++;
        if (go_a_log.size() < n0 + 2 || go_a_log[n0] !== 32'h4142_4344 || go_a_log[n0+1] !== 32'h4546_4748) begin
            errors++; $display("FAIL basic_operands: got %0d logged operands expected 41424344,45464748", go_a_log.size() - n0);
        end
        av_read(ADDR_RESULT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_result0: got %h expected 1", d); end
        av_read(ADDR_RESULT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_result1: got %h expected 1", d); end
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h000A_8000) begin errors++; $display("FAIL basic_status_drained: got %h expected 000a8000", d); end
    endtask

    task automatic test_empty_go();
        logic [31:0] d;
        do_clear();
        av_write(ADDR_CTRL, 32'h1);
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h000A_8000) begin errors++; $display("FAIL empty_go_status: got %h expected 000a8000", d); end
        av_write(ADDR_PUSH_A, 32'h55);
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL push_clears_done: got %h expected 00000001", d); end
    endtask

    task automatic test_mismatch();
        logic [31:0] d;
        int          g0;
        do_clear();
        av_write(ADDR_PUSH_A, 32'hA0); av_write(ADDR_PUSH_A, 32'hA1);
        av_write(ADDR_PUSH_B, 32'hB0);
        g0 = go_cnt;
        av_write(ADDR_CTRL, 32'h1);
        idle(4);
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0040_0022) begin errors++; $display("FAIL mismatch_status: got %h expected 00400022", d); end
        checks++; if (go_cnt !== g0) begin errors++; $display("FAIL mismatch_no_go: got %0d pulses expected 0", go_cnt - g0); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic        found, ok;
        int          g0, n0;
        do_clear();
        model_lat = 2; model_res = 32'h1;
        for (int i = 0; i < 17; i++) av_write(ADDR_PUSH_A, 32'h100 + i);
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0010_0010) begin errors++; $display("FAIL overflow_status: got %h expected 00100010", d); end
        for (int i = 0; i < 16; i++) av_write(ADDR_PUSH_B, 32'h200 + i);
        g0 = go_cnt; n0 = go_a_log.size();
        av_write(ADDR_CTRL, 32'h1);
        poll_status(32'h0008_0000, 32'h0008_0000, 400, found, d);
        checks++; if (!found) begin errors++; $display("FAIL overflow_done_timeout: got status %h expected done bit", d); end
        checks++; if (d !== 32'h001A_C000) begin errors++; $display("FAIL overflow_final_status: got %h expected 001ac000", d); end
        checks++; if (go_cnt - g0 !== 16) begin errors++; $display("FAIL overflow_go_pulses: got %0d expected 16", go_cnt - g0); end
        ok = (go_a_log.size() >= n0 + 16);
        for (int i = 0; i < 16 && ok; i++) if (go_a_log[n0+i] !== 32'h100 + i) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL overflow_operand_seq: got %0d logged operands expected 00000100..0000010f in order", go_a_log.size() - n0); end
    endtask

    task automatic test_underflow();
        logic [31:0] d;
        do_clear();
        av_read(ADDR_RESULT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL underflow_data: got %h expected 0", d); end
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0020_0000) begin errors++; $display("FAIL underflow_status: got %h expected 00200000", d); end
    endtask

    task automatic test_busy_drop();
        logic [31:0] d;
        logic        found;
        do_clear();
        model_lat = 6;
        av_write(ADDR_PUSH_A, 32'h11); av_write(ADDR_PUSH_B, 32'h22);
        av_write(ADDR_CTRL, 32'h1);
        poll_status(32'h0003_8000, 32'h0001_8000, 20, found, d);
        checks++; if (!found) begin errors++; $display("FAIL busy_wait_timeout: got status %h expected state WAIT", d); end
        av_write(ADDR_PUSH_A, 32'hDEAD);
        poll_status(32'h0008_0000, 32'h0008_0000, 40, found, d);
        checks++; if (d !== 32'h001A_8400) begin errors++; $display("FAIL busy_drop_status: got %h expected 001a8400", d); end
        model_lat = 2;
    endtask

    task automatic test_clear_mid();
        logic [31:0] d;
        logic        found;
        int          g0;
        do_clear();
        model_lat = 6;
        for (int i = 0; i < 4; i++) begin
            av_write(ADDR_PUSH_A, 32'h300 + i); av_write(ADDR_PUSH_B, 32'h400 + i);
        end
        g0 = go_cnt;
        av_write(ADDR_CTRL, 32'h1);
        poll_status(32'h0003_8000, 32'h0001_8000, 20, found, d);
        checks++; if (!found) begin errors++; $display("FAIL clear_wait_timeout: got status %h expected state WAIT", d); end
        av_write(ADDR_CTRL, 32'h2);
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_mid_status: got %h expected 0", d); end
        checks++; if (dp_go !== 1'b0) begin errors++; $display("FAIL clear_mid_dp_go: got %b expected 0", dp_go); end
        idle(10);
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_late_done: got %h expected 0", d); end
        checks++; if (go_cnt - g0 !== 1) begin errors++; $display("FAIL clear_go_pulses: got %0d expected 1", go_cnt - g0); end
        model_lat = 2;
    endtask

    task automatic test_stall();
        logic [31:0] d;
        logic        found;
        int          g0;
        do_clear();
        model_lat = 2; model_res = 32'h7;
        av_write(ADDR_PUSH_A, 32'h1); av_write(ADDR_PUSH_B, 32'h2);
        av_write(ADDR_CTRL, 32'h1);
        poll_status(32'h0008_0000, 32'h0008_0000, 20, found, d);
        checks++; if (!found) begin errors++; $display("FAIL stall_pre_timeout: got status %h expected done bit", d); end
        model_res = 32'h9;
        for (int i = 0; i < 16; i++) begin
            av_write(ADDR_PUSH_A, 32'h500 + i); av_write(ADDR_PUSH_B, 32'h600 + i);
        end
        g0 = go_cnt;
        av_write(ADDR_CTRL, 32'h1);
        poll_status(32'h0003_FC00, 32'h0002_4000, 300, found, d);
        checks++; if (!found) begin errors++; $display("FAIL stall_reach_timeout: got status %h expected STORE with countR 16", d); end
        idle(3);
        av_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0006_4000) begin errors++; $display("FAIL stall_held: got %h expected 00064000", d); end
        av_read(ADDR_RESULT, d);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL stall_pop_old: got %h expected 7", d); end
        poll_status(32'h0008_0000, 32'h0008_0000, 40, found, d);
        checks++; if (d !== 32'h000A_C000) begin errors++; $display("FAIL stall_resume_status: got %h expected 000ac000", d); end
        checks++; if (go_cnt - g0 !== 16) begin errors++; $display("FAIL stall_go_pulses: got %0d expected 16", go_cnt - g0); end
        av_read(ADDR_RESULT, d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL stall_pop_new: got %h expected 9", d); end
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_basic();
        test_empty_go();
        test_mismatch();
        test_overflow();
        test_underflow();
        test_busy_drop();
        test_clear_mid();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
